// File: rtl/sid_filter_sched.sv
// Sample-rate sequencer for the SID filter: issues input_valid ticks, captures the
// filter result, and double-buffers CPU register writes onto sample boundaries.
module sid_filter_sched #(
    parameter int CLK_DIV     = 32,
    parameter int FILT_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [1:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [7:0]  Fc_lo,
    output logic [7:0]  Fc_hi,
    output logic [7:0]  Res_Filt,
    output logic [7:0]  Mode_Vol,
    output logic        input_valid,
    input  logic [15:0] filt_sound,
    output logic [15:0] sample_out,
    output logic        sample_valid,
    output logic        overrun,
    input  logic        clr_overrun
);

    typedef enum logic [1:0] {IDLE, START, CAPTURE, BUSY} state_t;

    localparam logic [15:0] DIV_LOAD  = 16'(CLK_DIV - 1);
    localparam logic [7:0]  BUSY_LOAD = 8'(FILT_CYCLES - 2);

    state_t          state;
    logic [15:0]     div_cnt;
    logic [7:0]      busy_cnt;
    logic [3:0][7:0] shadow;
    logic [3:0][7:0] live;
    logic [3:0]      dirty;
    logic            tick;
    logic            commit;

    assign tick   = enable && (div_cnt == '0);
    assign commit = tick && (state == IDLE);

    assign rd_data  = shadow[rd_addr];
    assign Fc_lo    = live[0];
    assign Fc_hi    = live[1];
    assign Res_Filt = live[2];
    assign Mode_Vol = live[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= DIV_LOAD;
        end else if (enable) begin
            div_cnt <= (div_cnt == '0) ? DIV_LOAD : div_cnt - 16'd1;
        end
    end

    // A write landing on the commit cycle stays dirty: live takes the pre-write shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            live   <= '0;
            dirty  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (commit && dirty[i])
                    live[i] <= shadow[i];
                if (wr_en && wr_addr == 2'(i))
                    dirty[i] <= 1'b1;
                else if (commit)
                    dirty[i] <= 1'b0;
            end
            if (wr_en)
                shadow[wr_addr] <= wr_data;
        end
    end

    // START + CAPTURE + (FILT_CYCLES-2) BUSY cycles spans the filter schedule.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            input_valid  <= 1'b0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            busy_cnt     <= '0;
            overrun      <= 1'b0;
        end else begin
            input_valid  <= 1'b0;
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        input_valid <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    sample_out   <= filt_sound;
                    sample_valid <= 1'b1;
                    busy_cnt     <= BUSY_LOAD;
                    state        <= BUSY;
                end
                BUSY: begin
                    busy_cnt <= busy_cnt - 8'd1;
                    if (busy_cnt == 8'd1)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (tick && state != IDLE)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sid_filter_sched.sv
// Bench for sid_filter_sched: cycle model of sample timing and register buffering,
// plus a second instance at an over-fast divider to exercise overrun.
module tb_sid_filter_sched;

    localparam int D  = 32;
    localparam int FC = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, enable = 1'b0, wr_en = 1'b0, clr_overrun = 1'b0;
    logic [1:0]  wr_addr = '0, rd_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [15:0] filt_sound = '0;
    logic [7:0]  rd_data, Fc_lo, Fc_hi, Res_Filt, Mode_Vol;
    logic        input_valid, sample_valid, overrun;
    logic [15:0] sample_out;

    logic        rst8 = 1'b1, enable8 = 1'b0, clr8 = 1'b0;
    logic [7:0]  rd8, fl8, fh8, rf8, mv8;
    logic        iv8, sv8, ov8;
    logic [15:0] so8;
    logic        done8 = 1'b0;

    sid_filter_sched #(.CLK_DIV(D), .FILT_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .Fc_lo(Fc_lo),
        .Fc_hi(Fc_hi), .Res_Filt(Res_Filt), .Mode_Vol(Mode_Vol),
        .input_valid(input_valid), .filt_sound(filt_sound), .sample_out(sample_out),
        .sample_valid(sample_valid), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    sid_filter_sched #(.CLK_DIV(8), .FILT_CYCLES(FC)) dut8 (
        .clk(clk), .rst(rst8), .enable(enable8), .wr_en(1'b0), .wr_addr(2'd0),
        .wr_data(8'd0), .rd_addr(2'd0), .rd_data(rd8), .Fc_lo(fl8), .Fc_hi(fh8),
        .Res_Filt(rf8), .Mode_Vol(mv8), .input_valid(iv8), .filt_sound(16'hBEEF),
        .sample_out(so8), .sample_valid(sv8), .overrun(ov8), .clr_overrun(clr8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tick when the count of enabled cycles hits D-1 mod D;
    // sched = cycles of the filter schedule still to run (0 = idle).
    int          en_count, sched;
    logic [7:0]  m_shadow [4];
    logic [7:0]  m_live [4];
    bit          m_dirty [4];
    bit          m_iv, m_sv, m_ov, m_tk, m_busy, m_cap;
    logic [15:0] m_sample;
    logic [15:0] exp_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            en_count = 0; sched = 0; m_iv = 0; m_sv = 0; m_ov = 0; m_sample = '0;
            for (int i = 0; i < 4; i++) begin
                m_shadow[i] = '0; m_live[i] = '0; m_dirty[i] = 0;
            end
            exp_q.delete();
        end else begin
            m_tk = enable && (en_count % D == D - 1);
            if (enable) en_count++;
            m_busy = sched > 0;
            m_cap  = sched == FC - 1;
            if (m_busy) sched--;
            m_iv = 0;
            m_sv = 0;
            if (m_cap) begin
                m_sv = 1; m_sample = filt_sound; exp_q.push_back(filt_sound);
            end
            if (m_tk && !m_busy) begin
                for (int i = 0; i < 4; i++)
                    if (m_dirty[i]) begin m_live[i] = m_shadow[i]; m_dirty[i] = 0; end
                sched = FC;
                m_iv  = 1;
            end
            if (m_tk && m_busy) m_ov = 1;
            else if (clr_overrun) m_ov = 0;
            if (wr_en) begin m_shadow[wr_addr] = wr_data; m_dirty[wr_addr] = 1; end
        end
    end

    bit cmp_on = 0;
    bit prev_sv = 0;

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("input_valid", input_valid, m_iv);
            chk("sample_valid", sample_valid, m_sv);
            chk("sample_out", sample_out, m_sample);
            chk("sv_back_to_back", sample_valid && prev_sv, 0);
            if (sample_valid) begin
                if (exp_q.size() == 0) chk("sample_unexpected", 1, 0);
                else chk("sample_queue", sample_out, exp_q.pop_front());
            end
            chk("live_regs", {Fc_lo, Fc_hi, Res_Filt, Mode_Vol},
                {m_live[0], m_live[1], m_live[2], m_live[3]});
            chk("rd_data", rd_data, m_shadow[rd_addr]);
            chk("overrun", overrun, m_ov);
            prev_sv = sample_valid;
        end
    end

    bit hold_filt = 0;

    task automatic step();
        @(negedge clk);
        #1;
        if (!hold_filt) filt_sound = 16'($urandom);
    endtask

    task automatic wait_iv(output int n);
        n = 0;
        do begin step(); n++; end while (!input_valid && n < 200);
    endtask

    // Overrun instance: ticks every 8 clocks against a 12-clock schedule.
    initial begin
        int ivs [$];
        bit p_sv;
        p_sv = 0;
        repeat (3) @(negedge clk);
        #1;
        rst8 = 0;
        enable8 = 1;
        for (int s = 1; s <= 60; s++) begin
            @(negedge clk);
            #1;
            if (iv8) ivs.push_back(s);
            chk("dut8_sv_back_to_back", sv8 && p_sv, 0);
            p_sv = sv8;
            if (s == 15) chk("dut8_overrun_before", ov8, 0);
            if (s == 16) chk("dut8_overrun_set", ov8, 1);
            if (s == 27) chk("dut8_overrun_clr", ov8, 0);
            if (s == 32) chk("dut8_overrun_set_wins", ov8, 1);
            clr8 = (s == 26 || s == 31);
        end
        chk("dut8_iv_count", ivs.size(), 4);
        if (ivs.size() >= 2) begin
            chk("dut8_first_iv", ivs[0], 8);
            chk("dut8_second_iv", ivs[1], 24);
            for (int k = 1; k < ivs.size(); k++)
                chk("dut8_iv_spacing_ge12", (ivs[k] - ivs[k-1]) >= 12, 1);
        end
        done8 = 1;
    end

    initial begin
        int n;
        repeat (3) step();
        cmp_on = 1;
        chk("reset_live", {Fc_lo, Fc_hi, Res_Filt, Mode_Vol}, 0);
        chk("reset_flags", {input_valid, sample_valid, overrun}, 0);
        chk("reset_sample", sample_out, 0);

        rst = 0;
        enable = 1;
        wait_iv(n);
        chk("first_iv_latency", n, 32);
        step();
        chk("iv_width", input_valid, 0);
        wait_iv(n);
        chk("iv_period", n, 31);

        // Fc_hi write while BUSY
        repeat (3) step();
        wr_en = 1; wr_addr = 2'd1; wr_data = 8'hA5; rd_addr = 2'd1;
        step();
        wr_en = 0;
        chk("fc_hi_readback", rd_data, 8'hA5);
        chk("fc_hi_held", Fc_hi, 8'h00);
        wait_iv(n);
        chk("fc_hi_commit", Fc_hi, 8'hA5);

        // Mode_Vol write exactly on the tick cycle
        step();
        wr_en = 1; wr_addr = 2'd3; wr_data = 8'h0F;
        step();
        wr_en = 0;
        repeat (29) step();
        chk("mode_vol_pre", Mode_Vol, 8'h00);
        wr_en = 1; wr_addr = 2'd3; wr_data = 8'h1F; rd_addr = 2'd3;
        step();
        wr_en = 0;
        chk("tick_cycle_iv", input_valid, 1);
        chk("mode_vol_old_value", Mode_Vol, 8'h0F);
        chk("mode_vol_shadow", rd_data, 8'h1F);

        // Sample capture at the edge ending CAPTURE
        step();
        hold_filt = 1;
        filt_sound = 16'h1234;
        step();
        chk("sample_1234_valid", sample_valid, 1);
        chk("sample_1234", sample_out, 16'h1234);
        hold_filt = 0;
        step();
        chk("sample_valid_drop", sample_valid, 0);
        wait_iv(n);
        chk("mode_vol_new_value", Mode_Vol, 8'h1F);

        repeat (1500) begin
            step();
            enable      = $urandom_range(0, 9) != 0;
            wr_en       = $urandom_range(0, 3) == 0;
            wr_addr     = 2'($urandom_range(0, 3));
            wr_data     = 8'($urandom);
            rd_addr     = 2'($urandom_range(0, 3));
            clr_overrun = $urandom_range(0, 15) == 0;
        end

        // Asynchronous reset in BUSY
        enable = 1; wr_en = 0; clr_overrun = 0;
        wait_iv(n);
        repeat (4) step();
        rst = 1;
        #1;
        chk("rst_live", {Fc_lo, Fc_hi, Res_Filt, Mode_Vol}, 0);
        chk("rst_flags", {input_valid, sample_valid, overrun}, 0);
        chk("rst_sample", sample_out, 0);
        chk("rst_rd_data", rd_data, 0);
        step();
        step();
        rst = 0;
        wait_iv(n);
        chk("iv_after_rst", n, 32);
        repeat (40) step();

        for (int i = 0; i < 200 && !done8; i++) step();
        chk("dut8_done", done8, 1);
        cmp_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sid_filter_sched.md
Name: sid_filter_sched

Overview:
- Sequencer and register front end for the SID filter datapath.
- Generates the per-sample `input_valid` strobe at a fixed clock-divided rate and waits out the filter's 12-cycle compute schedule.
- Captures the filter's `sound` result into a sample register.
- Double-buffers CPU writes to the four filter registers, so filter configuration changes only on a sample boundary, never mid-computation.

Parameters:
- CLK_DIV, 32, clocks per sample tick; legal range 14..65535.
- FILT_CYCLES, 12, length of the filter's compute schedule in clocks, counted from the input_valid cycle.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- enable  input  1  when low, divider is held and no new ticks are issued
- wr_en  input  1  single-cycle CPU write strobe
- wr_addr  input  2  0=Fc_lo, 1=Fc_hi, 2=Res_Filt, 3=Mode_Vol
- wr_data  input  8  write data
- rd_addr  input  2  readback select, same map as wr_addr
- rd_data  output  8  shadow register readback (combinational from rd_addr)
- Fc_lo, Fc_hi, Res_Filt, Mode_Vol  output  8 each  live configuration driven to the filter
- input_valid  output  1  one-cycle start strobe to the filter
- filt_sound  input  16  filter `sound` output
- sample_out  output  16  captured sample
- sample_valid  output  1  one-cycle pulse when sample_out updates
- overrun  output  1  sticky flag: a tick arrived while the filter was busy
- clr_overrun  input  1  clears overrun

Behaviour:
- Reset (asynchronous): all shadow and live registers = 0, dirty[3:0] = 0, divider = CLK_DIV-1, state = IDLE, input_valid = 0, sample_out = 0, sample_valid = 0, overrun = 0.
- Divider:
  - When enable=1, counts down by 1 each clock.
  - At 0, asserts internal tick for one cycle and reloads CLK_DIV-1.
  - When enable=0, holds its value.
- Shadow writes:
  - wr_en=1 writes shadow[wr_addr] = wr_data and sets dirty[wr_addr].
  - rd_data = shadow[rd_addr].
- State machine (IDLE, START, CAPTURE, BUSY):
  - IDLE, on tick:
    - For each i with dirty[i]=1, copy shadow[i] to live[i].
    - Clear those dirty bits.
    - Register input_valid=1 for the next cycle.
    - Go to START.
  - START: input_valid=1 for exactly this cycle; go to CAPTURE.
  - CAPTURE:
    - At the clock edge ending this cycle, sample_out <= filt_sound and sample_valid=1 for one cycle.
    - filt_sound then holds the previous sample's result, because the filter updates `sound` on the edge that samples input_valid.
    - Load busy counter = FILT_CYCLES-2; go to BUSY.
  - BUSY:
    - Decrement the busy counter.
    - At 0, go to IDLE.
    - Total time from the START cycle to returning to IDLE = FILT_CYCLES clocks.
- Live registers are stable from the START cycle until the next IDLE commit.
- Write coinciding with commit: the commit copies the pre-write shadow value. The new write lands in shadow and dirty[i] stays set, so it commits on the next tick.
- Tick when state != IDLE:
  - Tick is dropped and overrun is set.
  - clr_overrun clears overrun; a simultaneous set wins.
  - With CLK_DIV >= 14, no overrun occurs.
- enable deasserted mid-schedule: the current sample completes normally; no further ticks.
- Asynchronous rst mid-schedule: immediate return to reset values. input_valid drops the same cycle; the filter is reset by the same rst.

Test Plan:
- Reset then enable=1, CLK_DIV=32: first input_valid pulse 32 clocks after release, then every 32 clocks, each exactly 1 cycle wide.
- Write Fc_hi=8'hA5 mid-schedule (state BUSY): Fc_hi output unchanged until the cycle after the next tick, then 8'hA5; rd_data(addr1) = 8'hA5 immediately.
- Write Mode_Vol=8'h1F on the exact tick cycle while shadow=8'h0F: live Mode_Vol=8'h0F for this sample, 8'h1F after the following tick.
- Drive filt_sound=16'h1234 around a sample: sample_out=16'h1234 with a sample_valid pulse at the edge ending CAPTURE (2 edges after input_valid rises); sample_valid is never high in two consecutive cycles.
- CLK_DIV=8 (illegal, forces overrun): overrun=1 after the second tick and input_valid spacing >= 12; clr_overrun returns it to 0.
- Assert rst during BUSY: all outputs 0 within the same cycle; the schedule restarts cleanly after release.
